// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline registers
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rw_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             UseRs_ID,
    input  logic             UseRt_ID,
    input  logic             Jump_ID,
    input  logic             BranchTaken_EX,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_en,
    output logic             ID_EX_flush,
    output logic             EX_MEM_en,
    output logic             MEM_WB_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_nx;
    logic [7:0] wait_cnt, wait_nx;
    logic mem_acc, ldu, at_limit, mem_stall, br, ld_stall, jmp, to_flag;
    // hazard decode and priority resolution: memory freeze, branch, load-use, jump
    always_comb begin
        mem_acc   = MemRead_MEM | MemWrite_MEM;
        ldu       = MemRead_EX && (Rw_EX != 5'd0) &&
                    ((UseRs_ID && rs_ID == Rw_EX) || (UseRt_ID && rt_ID == Rw_EX));
        at_limit  = (state == MEM_WAIT) && (wait_cnt >= LIMIT);
        mem_stall = mem_acc & ~dmem_ready & ~at_limit;
        br        = ~mem_stall & BranchTaken_EX;
        ld_stall  = ~mem_stall & ~BranchTaken_EX & ldu;
        jmp       = ~mem_stall & ~BranchTaken_EX & ~ldu & Jump_ID;
        dmem_req     = reset & mem_acc;
        PC_en        = reset & ~mem_stall & ~ld_stall;
        IF_ID_en     = reset & ~mem_stall & ~ld_stall;
        IF_ID_flush  = ~reset | br | jmp;
        ID_EX_en     = reset & ~mem_stall;
        ID_EX_flush  = ~reset | br | ld_stall;
        EX_MEM_en    = reset & ~mem_stall;
        MEM_WB_flush = ~reset | mem_stall;
    end
    // wait-state sequencing; abandoning at the limit raises the timeout
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        to_flag  = 1'b0;
        if (state == RUN) begin
            state_nx = mem_stall ? MEM_WAIT : RUN;
            wait_nx  = mem_stall ? 8'd1 : 8'd0;
        end else if (dmem_ready || !mem_acc) begin
            state_nx = RUN;
            wait_nx  = 8'd0;
        end else if (at_limit) begin
            state_nx = RUN;
            wait_nx  = 8'd0;
            to_flag  = 1'b1;
        end else begin
            wait_nx  = wait_cnt + 8'd1;
        end
    end
    // state, sticky timeout flag and saturating performance counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_nx;
            mem_timeout <= mem_timeout | to_flag;
            stall_cnt   <= ((mem_stall | ld_stall) && stall_cnt != CNT_MAX) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt   <= ((br | jmp) && flush_cnt != CNT_MAX) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors checked against a priority-table model
module tb_pipeline_hazard_ctrl;
    localparam int TO = 6;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0, reset = 1'b0;
    logic MemRead_EX, UseRs_ID, UseRt_ID, Jump_ID, BranchTaken_EX;
    logic MemRead_MEM, MemWrite_MEM, dmem_ready;
    logic [4:0] Rw_EX, rs_ID, rt_ID;
    logic dmem_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush;
    logic EX_MEM_en, MEM_WB_flush, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int checks = 0, passed = 0;
    bit run_chk = 0;
    int k = 0, m_sc = 0, m_fc = 0;
    bit m_to = 0;
    int p;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .Rw_EX(Rw_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
        .Jump_ID(Jump_ID), .BranchTaken_EX(BranchTaken_EX), .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_en(ID_EX_en), .ID_EX_flush(ID_EX_flush), .EX_MEM_en(EX_MEM_en),
        .MEM_WB_flush(MEM_WB_flush), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // k = stall cycles already spent on the current access; at most TO-1 allowed
    function automatic int prio();
        bit ma, hz;
        ma = MemRead_MEM || MemWrite_MEM;
        hz = MemRead_EX && Rw_EX != 0 &&
             ((UseRs_ID && rs_ID == Rw_EX) || (UseRt_ID && rt_ID == Rw_EX));
        if (ma && !dmem_ready && k < TO - 1) return 1;
        if (BranchTaken_EX) return 2;
        if (hz) return 3;
        if (Jump_ID) return 4;
        return 5;
    endfunction

    function automatic int sat(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(string n, int a, int e);
        checks++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            k <= 0; m_to <= 0; m_sc <= 0; m_fc <= 0;
        end else begin
            if (prio() == 1 || prio() == 3) m_sc <= sat(m_sc);
            if (prio() == 2 || prio() == 4) m_fc <= sat(m_fc);
            if (prio() == 1) k <= k + 1;
            else begin
                k <= 0;
                if ((MemRead_MEM || MemWrite_MEM) && !dmem_ready) m_to <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            p = prio();
            chk("dmem_req", dmem_req, int'(reset && (MemRead_MEM || MemWrite_MEM)));
            chk("PC_en", PC_en, int'(reset && p != 1 && p != 3));
            chk("IF_ID_en", IF_ID_en, int'(reset && p != 1 && p != 3));
            chk("IF_ID_flush", IF_ID_flush, int'(!reset || p == 2 || p == 4));
            chk("ID_EX_en", ID_EX_en, int'(reset && p != 1));
            chk("ID_EX_flush", ID_EX_flush, int'(!reset || p == 2 || p == 3));
            chk("EX_MEM_en", EX_MEM_en, int'(reset && p != 1));
            chk("MEM_WB_flush", MEM_WB_flush, int'(!reset || p == 1));
            chk("mem_timeout", mem_timeout, int'(m_to));
            chk("stall_cnt", stall_cnt, m_sc);
            chk("flush_cnt", flush_cnt, m_fc);
        end
    end

    task automatic idle();
        MemRead_EX = 0; Rw_EX = 0; rs_ID = 0; rt_ID = 0; UseRs_ID = 0; UseRt_ID = 0;
        Jump_ID = 0; BranchTaken_EX = 0; MemRead_MEM = 0; MemWrite_MEM = 0; dmem_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        run_chk = 1;
        step();
        reset = 1;
        // load-use on rs, then Rw_EX==0 which is never a hazard
        MemRead_EX = 1; Rw_EX = 8; rs_ID = 8; UseRs_ID = 1;
        #1; chk("t1 PC_en", PC_en, 0); chk("t1 ID_EX_flush", ID_EX_flush, 1);
        step(); idle(); #1; chk("t1 stall_cnt", stall_cnt, 1); chk("t1 PC_en after", PC_en, 1);
        MemRead_EX = 1; Rw_EX = 0; rs_ID = 0; UseRs_ID = 1;
        #1; chk("t1 r0 PC_en", PC_en, 1);
        step(); idle(); #1; chk("t1 r0 stall_cnt", stall_cnt, 1);
        // three wait cycles then ready, followed by a back-to-back access
        do_reset();
        MemRead_MEM = 1;
        repeat (3) begin
            #1; chk("t2 PC_en", PC_en, 0); chk("t2 MEM_WB_flush", MEM_WB_flush, 1); chk("t2 req", dmem_req, 1);
            step();
        end
        dmem_ready = 1;
        #1; chk("t2 release PC_en", PC_en, 1); chk("t2 release MEM_WB_flush", MEM_WB_flush, 0);
        step(); dmem_ready = 0;
        #1; chk("t2 b2b PC_en", PC_en, 0);
        step(); dmem_ready = 1; step(); idle();
        #1; chk("t2 stall_cnt", stall_cnt, 4);
        // store that is never acknowledged: TO-1 freeze cycles, then abandon
        do_reset();
        MemWrite_MEM = 1;
        repeat (TO - 1) begin
            #1; chk("t3 PC_en", PC_en, 0);
            step();
        end
        #1; chk("t3 abandon PC_en", PC_en, 1); chk("t3 flag before", mem_timeout, 0);
        step(); idle();
        #1; chk("t3 flag", mem_timeout, 1); chk("t3 stall_cnt", stall_cnt, TO - 1);
        repeat (3) step();
        chk("t3 flag sticky", mem_timeout, 1);
        // branch overrides load-use and jump; then a lone jump
        do_reset();
        BranchTaken_EX = 1; MemRead_EX = 1; Rw_EX = 5; rt_ID = 5; UseRt_ID = 1; Jump_ID = 1;
        #1; chk("t4 IF_ID_flush", IF_ID_flush, 1); chk("t4 ID_EX_flush", ID_EX_flush, 1); chk("t4 PC_en", PC_en, 1);
        step(); idle();
        #1; chk("t4 flush_cnt", flush_cnt, 1); chk("t4 stall_cnt", stall_cnt, 0);
        Jump_ID = 1;
        #1; chk("t4 jump IF_ID_flush", IF_ID_flush, 1); chk("t4 jump ID_EX_flush", ID_EX_flush, 0);
        step(); idle(); #1; chk("t4 jump flush_cnt", flush_cnt, 2);
        // branch held behind a memory wait
        do_reset();
        MemRead_MEM = 1; BranchTaken_EX = 1;
        repeat (2) begin
            #1; chk("t5 PC_en", PC_en, 0); chk("t5 IF_ID_flush", IF_ID_flush, 0);
            step();
        end
        dmem_ready = 1;
        #1; chk("t5 ready IF_ID_flush", IF_ID_flush, 1); chk("t5 ready PC_en", PC_en, 1);
        step(); idle();
        #1; chk("t5 flush_cnt", flush_cnt, 1); chk("t5 stall_cnt", stall_cnt, 2);
        // reset in the middle of a wait
        do_reset();
        MemRead_MEM = 1;
        step(); step();
        reset = 0;
        #1; chk("t6 PC_en", PC_en, 0); chk("t6 IF_ID_flush", IF_ID_flush, 1); chk("t6 req", dmem_req, 0);
        step();
        #1; chk("t6 stall_cnt", stall_cnt, 0); chk("t6 flag", mem_timeout, 0);
        reset = 1;
        #1; chk("t6 fresh PC_en", PC_en, 0);
        repeat (TO + 1) step();
        idle();
        // counter saturation
        do_reset();
        MemRead_EX = 1; Rw_EX = 3; rt_ID = 3; UseRt_ID = 1;
        repeat (CMAX + 5) step();
        idle(); #1; chk("t7 stall sat", stall_cnt, CMAX);
        Jump_ID = 1;
        repeat (CMAX + 3) step();
        idle(); #1; chk("t7 flush sat", flush_cnt, CMAX);
        repeat (2) step();
        run_chk = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
